da2dacrx: RTL and testbench
===========================

DA2DACRX -- requirements
Module: da2dacrx

Interface
REQ-001 SHALL have no parameters; frame length is fixed at 16 bits: 2 don't-care, cmd[1:0], data[11:0], MSB first.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 dacrxclk  in  1  system clock; all logic on its rising edge.
REQ-004 dacrxrst  in  1  asynchronous active-high reset.
REQ-005 dacsck  in  1  serial clock from the DAC transmitter; idles high; bits are valid during sck high and sampled at sck fall.
REQ-006 dacsync  in  1  frame strobe; falling edge starts a frame, rising edge ends it.
REQ-007 dacsdi  in  1  serial data; MSB first.
REQ-008 rxack  in  1  consumer acknowledge of rxcmd/rxdata.
REQ-009 rxcmd  out  2  received command bits.
REQ-010 rxdata  out  12  received data word.
REQ-011 rxdav  out  1  received word available; held until acknowledged.
REQ-012 rxerr  out  1  one-cycle pulse when a malformed frame is discarded.
REQ-013 rxovr  out  1  sticky overrun flag.
REQ-014 rxfrm  out  8  count of good frames; wraps 255->0.

Function
REQ-015 SHALL register dacsck, dacsync and dacsdi once (stage q), then register sck and sync again (stage d); edges are detected between stages q and d.
REQ-016 sck fall SHALL be sck_d=1 and sck_q=0; sync fall SHALL be sync_d=1 and sync_q=0; sync rise SHALL be sync_d=0 and sync_q=1.
REQ-017 SHALL implement FSM IDLE/RECV; IDLE->RECV on sync fall, which clears the 16-bit shift register and the 5-bit bit counter.
REQ-018 In RECV, each sck fall SHALL shift sdi_q into the LSB of the shift register and increment the bit counter, which saturates at 17.
REQ-019 In RECV, on sync rise with bit count = 16, SHALL load rxcmd = shift[13:12] and rxdata = shift[11:0], set rxdav=1, increment rxfrm, and go to IDLE.
REQ-020 In RECV, on sync rise with bit count != 16, SHALL keep rxcmd, rxdata, rxdav and rxfrm unchanged, pulse rxerr for 1 clock, and go to IDLE.
REQ-021 sck edges in IDLE SHALL be ignored.
REQ-022 A sync fall while in RECV SHALL restart the frame (clear shift register and counter) without flagging an error.
REQ-023 Latency: rxdav SHALL rise on the 2nd dacrxclk edge after the edge at which dacsync=1 is first sampled.
REQ-024 rxack=1 while rxdav=1 SHALL clear rxdav on the next clock.
REQ-025 rxack while rxdav=0 SHALL be ignored.
REQ-026 A good frame completing while rxdav=1 SHALL overwrite rxcmd/rxdata, keep rxdav=1 and set rxovr=1.
REQ-027 If a good frame completes in the same cycle as rxack, the new word wins: rxdav stays 1 and rxovr is not set.
REQ-028 rxovr SHALL clear only on reset.
REQ-029 SHALL tolerate sck toggling every dacrxclk cycle, which is the minimum half-period of 1 clock.

Reset
REQ-030 While dacrxrst=1, SHALL force: FSM=IDLE, counter=0, shift=0, rxcmd=0, rxdata=0, rxdav=0, rxerr=0, rxovr=0, rxfrm=0.
REQ-031 Reset SHALL set sck_q/sck_d=1 and sync_q/sync_d=1.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; reception resumes only at the next sync fall after release.
REQ-033 SHALL produce no rxerr and no rxdav as a result of reset release.

Verification
REQ-034 Good frame, cmd=2'b10, data=12'hA5C, sck half-period 1 clock -> rxcmd=2, rxdata=12'hA5C, rxdav=1 per REQ-023 timing, rxfrm=1, rxerr=0.
REQ-035 Short frame, sync rises after 15 sck falls -> rxerr pulses 1 cycle, rxdav=0, rxfrm unchanged; a following good frame with 12'h001 is received correctly.
REQ-036 Two good frames (12'h123, then 12'h456) with no rxack -> rxdata=12'h456, rxdav=1, rxovr=1, rxfrm=2; then rxack -> rxdav=0 next clock, rxovr stays 1.
REQ-037 Reset pulse after 8 bits of a frame -> all outputs 0; remaining sck/sync activity yields no rxdav and no rxerr; next frame 12'hFFF, cmd=3 is received.
REQ-038 256 good frames, each acknowledged -> rxfrm wraps to 0, rxovr=0 throughout.
REQ-039 Loopback with the DAC transmitter on the same clock, 100 random cmd/data values -> every word received matches the word sent, with no rxerr and no rxovr.

Source files
------------

// File: rtl/da2dacrx.sv
// Serial DAC-frame receiver: 16-bit frames (2 don't-care, 2 cmd, 12 data, MSB first),
// framed by dacsync and clocked by dacsck, oversampled on dacrxclk.
module da2dacrx (
   input  logic        dacrxclk,
   input  logic        dacrxrst,
   input  logic        dacsck,
   input  logic        dacsync,
   input  logic        dacsdi,
   input  logic        rxack,
   output logic [1:0]  rxcmd,
   output logic [11:0] rxdata,
   output logic        rxdav,
   output logic        rxerr,
   output logic        rxovr,
   output logic [7:0]  rxfrm
);

   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

   state_t      state, state_nxt;
   logic        sck_q, sync_q, sdi_q, sck_d, sync_d;
   logic        armed;
   logic [13:0] shift, shift_nxt;
   logic [4:0]  cnt, cnt_nxt;
   logic        good, good_nxt, bad, bad_nxt;
   logic        sck_fall, sync_fall, sync_rise;

   // Two-stage input sampling; armed blocks a false sync fall seen against the reset value.
   always_ff @(posedge dacrxclk or posedge dacrxrst) begin
      if (dacrxrst) begin
         sck_q  <= 1'b1;
         sync_q <= 1'b1;
         sdi_q  <= 1'b0;
         sck_d  <= 1'b1;
         sync_d <= 1'b1;
         armed  <= 1'b0;
      end else begin
         sck_q  <= dacsck;
         sync_q <= dacsync;
         sdi_q  <= dacsdi;
         sck_d  <= sck_q;
         sync_d <= sync_q;
         if (dacsync) begin
            armed <= 1'b1;
         end else begin
            armed <= armed;
         end
      end
   end

   assign sck_fall  = sck_d & ~sck_q;
   assign sync_fall = sync_d & ~sync_q & armed;
   assign sync_rise = ~sync_d & sync_q;

   // Frame state register.
   always_ff @(posedge dacrxclk or posedge dacrxrst) begin
      if (dacrxrst) begin
         state <= IDLE;
         shift <= 14'd0;
         cnt   <= 5'd0;
         good  <= 1'b0;
         bad   <= 1'b0;
      end else begin
         state <= state_nxt;
         shift <= shift_nxt;
         cnt   <= cnt_nxt;
         good  <= good_nxt;
         bad   <= bad_nxt;
      end
   end

   // Next-state logic; the two leading don't-care bits simply shift out of the top.
   always_comb begin
      state_nxt = state;
      shift_nxt = shift;
      cnt_nxt   = cnt;
      good_nxt  = 1'b0;
      bad_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (sync_fall) begin
               state_nxt = RECV;
               shift_nxt = 14'd0;
               cnt_nxt   = 5'd0;
            end else begin
               state_nxt = IDLE;
            end
         end
         RECV: begin
            if (sync_fall) begin
               shift_nxt = 14'd0;
               cnt_nxt   = 5'd0;
            end else if (sync_rise) begin
               state_nxt = IDLE;
               if (cnt == 5'd16) begin
                  good_nxt = 1'b1;
               end else begin
                  bad_nxt = 1'b1;
               end
            end else if (sck_fall) begin
               shift_nxt = {shift[12:0], sdi_q};
               if (cnt != 5'd17) begin
                  cnt_nxt = cnt + 5'd1;
               end else begin
                  cnt_nxt = cnt;
               end
            end else begin
               state_nxt = RECV;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output word, handshake, overrun and frame counter; a completing frame beats rxack.
   always_ff @(posedge dacrxclk or posedge dacrxrst) begin
      if (dacrxrst) begin
         rxcmd  <= 2'd0;
         rxdata <= 12'd0;
         rxdav  <= 1'b0;
         rxerr  <= 1'b0;
         rxovr  <= 1'b0;
         rxfrm  <= 8'd0;
      end else begin
         rxerr <= bad;
         if (good) begin
            rxcmd  <= shift[13:12];
            rxdata <= shift[11:0];
            rxdav  <= 1'b1;
            rxfrm  <= rxfrm + 8'd1;
            if (rxdav && !rxack) begin
               rxovr <= 1'b1;
            end else begin
               rxovr <= rxovr;
            end
         end else if (rxack) begin
            rxdav <= 1'b0;
         end else begin
            rxdav <= rxdav;
         end
      end
   end

endmodule

// File: tb/tb_da2dacrx.sv
// Directed bench for da2dacrx: bench-side transmitter drives frames; expectations are hand-derived.
module tb_da2dacrx;

   logic        clk, rst, sck, sync, sdi, ack;
   logic [1:0]  rxcmd;
   logic [11:0] rxdata;
   logic        rxdav, rxerr, rxovr;
   logic [7:0]  rxfrm;

   int checks   = 0;
   int failures = 0;
   int err_cnt  = 0;
   logic [7:0] exp_frm = 8'd0;

   da2dacrx dut (
      .dacrxclk(clk), .dacrxrst(rst), .dacsck(sck), .dacsync(sync), .dacsdi(sdi),
      .rxack(ack), .rxcmd(rxcmd), .rxdata(rxdata), .rxdav(rxdav), .rxerr(rxerr),
      .rxovr(rxovr), .rxfrm(rxfrm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // counts every clock cycle rxerr is high
   always @(posedge clk) if (rxerr) err_cnt++;

   task automatic send_frame(input logic [1:0] cmd, input logic [11:0] data,
                             input int nbits, input int half, input bit finish);
      logic [15:0] w;
      w = {2'b11, cmd, data};
      @(negedge clk);
      sync = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         sdi = w[15-i];
         sck = 1'b1;
         repeat (half) @(negedge clk);
         sck = 1'b0;
         repeat (half) @(negedge clk);
      end
      sck = 1'b1;
      if (finish) begin
         repeat (half) @(negedge clk);
         sync = 1'b1;
      end
   endtask

   task automatic settle();
      repeat (5) @(negedge clk);
   endtask

   task automatic do_ack();
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      checks++;
      if (rxdav !== 1'b0) begin
         failures++;
         $display("FAIL ack_clear: rxdav=%b required 0", rxdav);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_frm = 8'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1; sck = 1'b1; sync = 1'b1; sdi = 1'b0; ack = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({rxcmd, rxdata, rxdav, rxerr, rxovr, rxfrm} !== 25'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %h required 0", {rxcmd, rxdata, rxdav, rxerr, rxovr, rxfrm});
      end
      rst = 1'b0;
      settle();
      checks++;
      if (rxdav !== 1'b0 || err_cnt !== 0) begin
         failures++;
         $display("FAIL reset_release: rxdav=%b errs=%0d required 0/0", rxdav, err_cnt);
      end
   endtask

   task automatic test_good_frame();
      int e0;
      e0 = err_cnt;
      send_frame(2'b10, 12'hA5C, 16, 1, 1'b0);
      @(negedge clk);
      sync = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (rxdav !== 1'b0) begin failures++; $display("FAIL latency_e0: rxdav=%b required 0", rxdav); end
      @(posedge clk); #1;
      checks++;
      if (rxdav !== 1'b0) begin failures++; $display("FAIL latency_e1: rxdav=%b required 0", rxdav); end
      @(posedge clk); #1;
      checks++;
      if (rxdav !== 1'b1) begin failures++; $display("FAIL latency_e2: rxdav=%b required 1", rxdav); end
      exp_frm = exp_frm + 8'd1;
      settle();
      checks++;
      if (rxcmd !== 2'd2 || rxdata !== 12'hA5C || rxfrm !== exp_frm || err_cnt !== e0) begin
         failures++;
         $display("FAIL good_frame: cmd=%0d data=%h frm=%0d errs=%0d required 2 a5c %0d %0d",
                  rxcmd, rxdata, rxfrm, err_cnt - e0, exp_frm, 0);
      end
      do_ack();
   endtask

   task automatic test_short_frame();
      int e0;
      e0 = err_cnt;
      send_frame(2'b01, 12'h777, 15, 1, 1'b1);
      settle();
      checks++;
      if (err_cnt - e0 !== 1 || rxdav !== 1'b0 || rxfrm !== exp_frm || rxdata !== 12'hA5C) begin
         failures++;
         $display("FAIL short_frame: errcycles=%0d dav=%b frm=%0d data=%h required 1 0 %0d a5c",
                  err_cnt - e0, rxdav, rxfrm, rxdata, exp_frm);
      end
      send_frame(2'b01, 12'h001, 16, 2, 1'b1);
      settle();
      exp_frm = exp_frm + 8'd1;
      checks++;
      if (rxcmd !== 2'd1 || rxdata !== 12'h001 || rxdav !== 1'b1 || rxfrm !== exp_frm) begin
         failures++;
         $display("FAIL after_short: cmd=%0d data=%h dav=%b frm=%0d required 1 001 1 %0d",
                  rxcmd, rxdata, rxdav, rxfrm, exp_frm);
      end
      do_ack();
   endtask

   task automatic test_ack_ignored();
      @(negedge clk); ack = 1'b1;
      repeat (3) @(negedge clk); ack = 1'b0;
      settle();
      checks++;
      if (rxdav !== 1'b0 || rxovr !== 1'b0 || rxdata !== 12'h001) begin
         failures++;
         $display("FAIL ack_idle: dav=%b ovr=%b data=%h required 0 0 001", rxdav, rxovr, rxdata);
      end
   endtask

   task automatic test_overrun();
      send_frame(2'b00, 12'h123, 16, 1, 1'b1);
      settle();
      send_frame(2'b11, 12'h456, 16, 1, 1'b1);
      settle();
      exp_frm = exp_frm + 8'd2;
      checks++;
      if (rxdata !== 12'h456 || rxcmd !== 2'd3 || rxdav !== 1'b1 || rxovr !== 1'b1 || rxfrm !== exp_frm) begin
         failures++;
         $display("FAIL overrun: data=%h cmd=%0d dav=%b ovr=%b frm=%0d required 456 3 1 1 %0d",
                  rxdata, rxcmd, rxdav, rxovr, rxfrm, exp_frm);
      end
      do_ack();
      settle();
      checks++;
      if (rxovr !== 1'b1) begin failures++; $display("FAIL ovr_sticky: ovr=%b required 1", rxovr); end
   endtask

   task automatic test_reset_midframe();
      int e0;
      send_frame(2'b01, 12'h0F0, 8, 1, 1'b0);
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({rxcmd, rxdata, rxdav, rxerr, rxovr, rxfrm} !== 25'd0) begin
         failures++;
         $display("FAIL midframe_reset: got %h required 0", {rxcmd, rxdata, rxdav, rxerr, rxovr, rxfrm});
      end
      rst = 1'b0;
      exp_frm = 8'd0;
      e0 = err_cnt;
      for (int i = 0; i < 8; i++) begin
         sck = 1'b0; @(negedge clk);
         sck = 1'b1; @(negedge clk);
      end
      sync = 1'b1;
      settle();
      checks++;
      if (rxdav !== 1'b0 || err_cnt !== e0 || rxfrm !== 8'd0) begin
         failures++;
         $display("FAIL midframe_tail: dav=%b errs=%0d frm=%0d required 0 0 0", rxdav, err_cnt - e0, rxfrm);
      end
      send_frame(2'b11, 12'hFFF, 16, 1, 1'b1);
      settle();
      exp_frm = 8'd1;
      checks++;
      if (rxcmd !== 2'd3 || rxdata !== 12'hFFF || rxdav !== 1'b1 || rxfrm !== exp_frm) begin
         failures++;
         $display("FAIL after_reset_frame: cmd=%0d data=%h dav=%b frm=%0d required 3 fff 1 1",
                  rxcmd, rxdata, rxdav, rxfrm);
      end
   endtask

   task automatic test_back_to_back_ack();
      send_frame(2'b10, 12'h3C3, 16, 1, 1'b0);
      @(negedge clk); sync = 1'b1;
      @(negedge clk);
      @(negedge clk); ack = 1'b1;
      @(negedge clk); ack = 1'b0;
      exp_frm = exp_frm + 8'd1;
      checks++;
      if (rxdav !== 1'b1 || rxovr !== 1'b0 || rxdata !== 12'h3C3 || rxfrm !== exp_frm) begin
         failures++;
         $display("FAIL same_cycle_ack: dav=%b ovr=%b data=%h frm=%0d required 1 0 3c3 %0d",
                  rxdav, rxovr, rxdata, rxfrm, exp_frm);
      end
      do_ack();
   endtask

   task automatic test_wrap();
      bit ovr_seen;
      ovr_seen = 1'b0;
      pulse_reset();
      settle();
      for (int k = 0; k < 256; k++) begin
         send_frame(k[1:0], k[11:0], 16, 1, 1'b1);
         settle();
         if (rxovr) ovr_seen = 1'b1;
         if (k == 254) begin
            checks++;
            if (rxfrm !== 8'd255) begin failures++; $display("FAIL frm_255: frm=%0d required 255", rxfrm); end
         end
         do_ack();
      end
      checks++;
      if (rxfrm !== 8'd0 || ovr_seen) begin
         failures++;
         $display("FAIL frm_wrap: frm=%0d ovr_seen=%b required 0 0", rxfrm, ovr_seen);
      end
   endtask

   task automatic test_loopback();
      logic [1:0]  c;
      logic [11:0] d;
      int e0, bad;
      e0 = err_cnt;
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         c = 2'($urandom_range(0, 3));
         d = 12'($urandom);
         send_frame(c, d, 16, $urandom_range(1, 3), 1'b1);
         settle();
         checks++;
         if (rxcmd !== c || rxdata !== d || rxdav !== 1'b1) begin
            failures++;
            $display("FAIL loopback_%0d: cmd=%0d data=%h dav=%b required %0d %h 1", k, rxcmd, rxdata, rxdav, c, d);
         end
         do_ack();
      end
      checks++;
      if (err_cnt !== e0 || rxovr !== 1'b0) begin
         failures++;
         $display("FAIL loopback_clean: errs=%0d ovr=%b required 0 0", err_cnt - e0, rxovr);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_short_frame();
      test_ack_ignored();
      test_overrun();
      test_reset_midframe();
      test_back_to_back_ack();
      test_wrap();
      test_loopback();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
